axil_csr_slave: RTL and testbench

AXIL_CSR_SLAVE -- requirements
Module: axil_csr_slave

---
 rtl/axil_csr_slave.sv | 251 +++++++++++++++++++++++++
 tb/tb_axil_csr_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_csr_slave.sv
// -----------------------------------------------------------------------------
// axil_csr_slave
// AXI4-Lite slave exposing NREG 32-bit control/status registers.
//
// Ports
//   clk, resetn            sole clock (rising edge), asynchronous active-low reset
//   s_axi_csrs_aw*         write address channel (awaddr, awvalid, awready)
//   s_axi_csrs_w*          write data channel (wdata, wstrb, wvalid, wready)
//   s_axi_csrs_b*          write response channel (bresp, bvalid, bready)
//   s_axi_csrs_ar*         read address channel (araddr, arvalid, arready)
//   s_axi_csrs_r*          read data channel (rdata, rresp, rvalid, rready)
//   regs_out               r[i] on bits [32i+31:32i]
//   status_in              core status, returned on reads of offset 0
//   cmd_pulse              one-cycle strobe after a committed write to r0
//
// Address decode: index = addr[2+log2(NREG)-1:2], addr[1:0] ignored, any set bit
// above the index field makes the access out of range (SLVERR, no side effect).
// Read and write channels are completely independent. A read handshaking on
// the same edge as a write commit returns the pre-write register value.
// -----------------------------------------------------------------------------
module axil_csr_slave #(
    parameter int ADDR_W = 12,
    parameter int NREG   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [ADDR_W-1:0]    s_axi_csrs_awaddr,
    input  logic                 s_axi_csrs_awvalid,
    output logic                 s_axi_csrs_awready,
    input  logic [31:0]          s_axi_csrs_wdata,
    input  logic [3:0]           s_axi_csrs_wstrb,
    input  logic                 s_axi_csrs_wvalid,
    output logic                 s_axi_csrs_wready,
    output logic [1:0]           s_axi_csrs_bresp,
    output logic                 s_axi_csrs_bvalid,
    input  logic                 s_axi_csrs_bready,
    input  logic [ADDR_W-1:0]    s_axi_csrs_araddr,
    input  logic                 s_axi_csrs_arvalid,
    output logic                 s_axi_csrs_arready,
    output logic [31:0]          s_axi_csrs_rdata,
    output logic [1:0]           s_axi_csrs_rresp,
    output logic                 s_axi_csrs_rvalid,
    input  logic                 s_axi_csrs_rready,
    output logic [32*NREG-1:0]   regs_out,
    input  logic [31:0]          status_in,
    output logic                 cmd_pulse
);

    localparam int IDX_W = $clog2(NREG);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // True when any address bit above the register index field is set.
    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr);
        return |(addr >> (2 + IDX_W));
    endfunction

    // Byte-lane merge: lanes with a set strobe take the new data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Register file and write-side state
    logic [NREG-1:0][31:0] regs_r;
    wr_state_t             wr_state_r;
    logic                  aw_held_r;
    logic                  w_held_r;
    logic [ADDR_W-1:0]     awaddr_r;
    logic [31:0]           wdata_r;
    logic [3:0]            wstrb_r;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic                  cmd_pulse_r;
    logic [IDX_W-1:0]      aw_idx_s;

    // Read-side state
    rd_state_t             rd_state_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic [31:0]           rdata_r;
    logic [1:0]            rresp_r;
    logic [IDX_W-1:0]      rd_idx_s;
    logic [31:0]           rd_data_s;

    assign aw_idx_s = awaddr_r[2 +: IDX_W];
    assign rd_idx_s = s_axi_csrs_araddr[2 +: IDX_W];

    // Write FSM: independent AW/W capture, commit once both are held, then B handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs_r      <= '0;
            wr_state_r  <= W_IDLE;
            aw_held_r   <= 1'b0;
            w_held_r    <= 1'b0;
            awaddr_r    <= '0;
            wdata_r     <= 32'h0;
            wstrb_r     <= 4'h0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
            cmd_pulse_r <= 1'b0;
        end else begin
            cmd_pulse_r <= 1'b0;
            case (wr_state_r)
                W_IDLE: begin
                    if (aw_held_r && w_held_r) begin
                        // Commit cycle: both halves held since the previous edge.
                        aw_held_r  <= 1'b0;
                        w_held_r   <= 1'b0;
                        bvalid_r   <= 1'b1;
                        wr_state_r <= W_RESP;
                        if (addr_oor(awaddr_r)) begin
                            bresp_r <= RESP_SLVERR;
                        end else begin
                            bresp_r          <= RESP_OKAY;
                            regs_r[aw_idx_s] <= merge_bytes(regs_r[aw_idx_s], wdata_r, wstrb_r);
                            if ((aw_idx_s == '0) && (wstrb_r != 4'h0)) begin
                                cmd_pulse_r <= 1'b1;
                            end else begin
                                cmd_pulse_r <= 1'b0;
                            end
                        end
                    end else begin
                        if (awready_r && s_axi_csrs_awvalid) begin
                            aw_held_r <= 1'b1;
                            awaddr_r  <= s_axi_csrs_awaddr;
                            awready_r <= 1'b0;
                        end else begin
                            awready_r <= ~aw_held_r;
                        end
                        if (wready_r && s_axi_csrs_wvalid) begin
                            w_held_r <= 1'b1;
                            wdata_r  <= s_axi_csrs_wdata;
                            wstrb_r  <= s_axi_csrs_wstrb;
                            wready_r <= 1'b0;
                        end else begin
                            wready_r <= ~w_held_r;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_csrs_bready) begin
                        bvalid_r   <= 1'b0;
                        bresp_r    <= RESP_OKAY;
                        awready_r  <= 1'b1;
                        wready_r   <= 1'b1;
                        wr_state_r <= W_IDLE;
                    end else begin
                        bvalid_r   <= 1'b1;
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    aw_held_r  <= 1'b0;
                    w_held_r   <= 1'b0;
                    bvalid_r   <= 1'b0;
                    awready_r  <= 1'b0;
                    wready_r   <= 1'b0;
                end
            endcase
        end
    end

    // Read data selection for the AR handshake edge (offset 0 reads core status).
    always_comb begin
        rd_data_s = 32'h0;
        if (addr_oor(s_axi_csrs_araddr)) begin
            rd_data_s = 32'h0;
        end else if (rd_idx_s == '0) begin
            rd_data_s = status_in;
        end else begin
            rd_data_s = regs_r[rd_idx_s];
        end
    end

    // Read FSM: accept AR in R_IDLE, hold R until rready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'h0;
            rresp_r    <= RESP_OKAY;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (arready_r && s_axi_csrs_arvalid) begin
                        arready_r  <= 1'b0;
                        rvalid_r   <= 1'b1;
                        rdata_r    <= rd_data_s;
                        rresp_r    <= addr_oor(s_axi_csrs_araddr) ? RESP_SLVERR : RESP_OKAY;
                        rd_state_r <= R_DATA;
                    end else begin
                        arready_r  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_csrs_rready) begin
                        rvalid_r   <= 1'b0;
                        arready_r  <= 1'b1;
                        rd_state_r <= R_IDLE;
                    end else begin
                        rvalid_r   <= 1'b1;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    rvalid_r   <= 1'b0;
                    arready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_csrs_awready = awready_r;
    assign s_axi_csrs_wready  = wready_r;
    assign s_axi_csrs_bvalid  = bvalid_r;
    assign s_axi_csrs_bresp   = bresp_r;
    assign s_axi_csrs_arready = arready_r;
    assign s_axi_csrs_rvalid  = rvalid_r;
    assign s_axi_csrs_rdata   = rdata_r;
    assign s_axi_csrs_rresp   = rresp_r;
    assign regs_out           = regs_r;
    assign cmd_pulse          = cmd_pulse_r;

endmodule

// File: tb/tb_axil_csr_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_csr_slave
// Table-driven bench for axil_csr_slave (ADDR_W=12, NREG=8): a vector table of
// write/read transactions with hand-computed results, followed by hand-written
// sequences for reset mid-transaction and read/write on the same edge.
// -----------------------------------------------------------------------------
module tb_axil_csr_slave;

    logic         clk = 1'b0;
    logic         resetn;
    logic [11:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [11:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] regs_out;
    logic [31:0]  status_in;
    logic         cmd_pulse;

    axil_csr_slave #(.ADDR_W(12), .NREG(8)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .s_axi_csrs_awaddr  (awaddr),
        .s_axi_csrs_awvalid (awvalid),
        .s_axi_csrs_awready (awready),
        .s_axi_csrs_wdata   (wdata),
        .s_axi_csrs_wstrb   (wstrb),
        .s_axi_csrs_wvalid  (wvalid),
        .s_axi_csrs_wready  (wready),
        .s_axi_csrs_bresp   (bresp),
        .s_axi_csrs_bvalid  (bvalid),
        .s_axi_csrs_bready  (bready),
        .s_axi_csrs_araddr  (araddr),
        .s_axi_csrs_arvalid (arvalid),
        .s_axi_csrs_arready (arready),
        .s_axi_csrs_rdata   (rdata),
        .s_axi_csrs_rresp   (rresp),
        .s_axi_csrs_rvalid  (rvalid),
        .s_axi_csrs_rready  (rready),
        .regs_out           (regs_out),
        .status_in          (status_in),
        .cmd_pulse          (cmd_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;
    logic [7:0][31:0] exp_regs;

    // Count cycles with cmd_pulse high, sampled mid-cycle.
    always @(negedge clk) begin
        if (cmd_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        is_wr;
        int          mode;       // write: 0 AW+W together, 1 W two cycles before AW, 2 AW then W
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] status;
        int          hold;       // cycles bready/rready held low after valid
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_pulses;
        int          reg_idx;    // register changed by a write, -1 for none
        logic [31:0] exp_reg;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int hold, input logic [1:0] er, input int ep);
        int g;
        int lat;
        int p0;
        logic ok;
        logic [1:0] br;
        p0 = pulse_cnt;
        g = 0;
        while (!(awready && wready) && g < 20) begin tick(); g++; end
        chk("wr_ready", g < 20, 1'b1);
        awaddr = a; wdata = d; wstrb = s;
        case (mode)
            0: begin
                awvalid = 1'b1; wvalid = 1'b1; tick(); awvalid = 1'b0; wvalid = 1'b0;
            end
            1: begin
                wvalid = 1'b1; tick(); wvalid = 1'b0;
                chk("w_first_readys", {awready, wready}, 2'b10);
                tick();
                awvalid = 1'b1; tick(); awvalid = 1'b0;
            end
            default: begin
                awvalid = 1'b1; tick(); awvalid = 1'b0;
                chk("aw_first_readys", {awready, wready}, 2'b01);
                wvalid = 1'b1; tick(); wvalid = 1'b0;
            end
        endcase
        lat = 1;
        while (!bvalid && lat < 10) begin tick(); lat++; end
        chk("b_latency", lat, 2);
        chk("bresp", bresp, er);
        br = bresp;
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!(bvalid === 1'b1 && bresp === br)) ok = 1'b0;
        end
        chk("b_hold", ok, 1'b1);
        bready = 1'b1; tick(); bready = 1'b0;
        chk("b_done", {bvalid, awready, wready}, 3'b011);
        tick(); tick();
        chk("cmd_pulse_count", pulse_cnt - p0, ep);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [31:0] st, input int hold,
                           input logic [1:0] er, input logic [31:0] ed);
        int g;
        logic ok;
        logic [31:0] rd;
        logic [1:0] rr;
        g = 0;
        while (!arready && g < 20) begin tick(); g++; end
        chk("rd_ready", g < 20, 1'b1);
        status_in = st; araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        status_in = ~st;   // later status changes must not disturb captured data
        chk("r_latency", {rvalid, arready}, 2'b10);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        rd = rdata; rr = rresp; ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!(rvalid === 1'b1 && rdata === rd && rresp === rr)) ok = 1'b0;
        end
        chk("r_hold", ok, 1'b1);
        rready = 1'b1; tick(); rready = 1'b0;
        chk("r_done", {rvalid, arready}, 2'b01);
    endtask

    initial begin
        int lat;
        resetn = 1'b0;
        awaddr = 12'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
        bready = 1'b0; araddr = 12'h0; arvalid = 1'b0; rready = 1'b0; status_in = 32'h0;
        exp_regs = '0;

        //                 wr    mode addr     data          strb   status        hold resp   rdata         pul idx exp_reg
        vecs[0]  = '{1'b1, 0, 12'h008, 32'h80000000, 4'hF, 32'h0,        0, 2'b00, 32'h0,        0,  2, 32'h80000000};
        vecs[1]  = '{1'b1, 1, 12'h000, 32'h00000003, 4'hF, 32'h0,        0, 2'b00, 32'h0,        1,  0, 32'h00000003};
        vecs[2]  = '{1'b1, 0, 12'h004, 32'h6e6f7071, 4'hF, 32'h0,        0, 2'b00, 32'h0,        0,  1, 32'h6e6f7071};
        vecs[3]  = '{1'b1, 2, 12'h004, 32'hAAAABBBB, 4'h3, 32'h0,        2, 2'b00, 32'h0,        0,  1, 32'h6e6fBBBB};
        vecs[4]  = '{1'b1, 0, 12'h006, 32'h12345678, 4'h8, 32'h0,        0, 2'b00, 32'h0,        0,  1, 32'h126fBBBB};
        vecs[5]  = '{1'b1, 1, 12'h01C, 32'hDEADBEEF, 4'h5, 32'h0,        0, 2'b00, 32'h0,        0,  7, 32'h00AD00EF};
        vecs[6]  = '{1'b1, 0, 12'h040, 32'hFFFFFFFF, 4'hF, 32'h0,        0, 2'b10, 32'h0,        0, -1, 32'h0};
        vecs[7]  = '{1'b1, 0, 12'h000, 32'hFFFFFFFF, 4'h0, 32'h0,        0, 2'b00, 32'h0,        0,  0, 32'h00000003};
        vecs[8]  = '{1'b1, 2, 12'h800, 32'h12345678, 4'hF, 32'h0,        0, 2'b10, 32'h0,        0, -1, 32'h0};
        vecs[9]  = '{1'b1, 0, 12'h020, 32'h11111111, 4'hF, 32'h0,        0, 2'b10, 32'h0,        0, -1, 32'h0};
        vecs[10] = '{1'b1, 0, 12'h000, 32'h00000100, 4'h2, 32'h0,        3, 2'b00, 32'h0,        1,  0, 32'h00000103};
        vecs[11] = '{1'b0, 0, 12'h000, 32'h0,        4'h0, 32'h00000008, 5, 2'b00, 32'h00000008, 0, -1, 32'h0};
        vecs[12] = '{1'b0, 0, 12'h004, 32'h0,        4'h0, 32'h0,        0, 2'b00, 32'h126fBBBB, 0, -1, 32'h0};
        vecs[13] = '{1'b0, 0, 12'h01C, 32'h0,        4'h0, 32'h0,        1, 2'b00, 32'h00AD00EF, 0, -1, 32'h0};
        vecs[14] = '{1'b0, 0, 12'h040, 32'h0,        4'h0, 32'h00000055, 0, 2'b10, 32'h0,        0, -1, 32'h0};
        vecs[15] = '{1'b0, 0, 12'h008, 32'h0,        4'h0, 32'h0,        2, 2'b00, 32'h80000000, 0, -1, 32'h0};
        vecs[16] = '{1'b0, 0, 12'h003, 32'h0,        4'h0, 32'hCAFE0001, 0, 2'b00, 32'hCAFE0001, 0, -1, 32'h0};
        vecs[17] = '{1'b0, 0, 12'h01F, 32'h0,        4'h0, 32'h0,        0, 2'b00, 32'h00AD00EF, 0, -1, 32'h0};

        // Reset state and ready rise after release
        #3;
        chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, cmd_pulse}, 6'b0);
        chk("reset_regs", regs_out, 256'h0);
        tick();
        resetn = 1'b1;
        chk("readys_before_edge", {awready, wready, arready}, 3'b000);
        tick();
        chk("readys_after_release", {awready, wready, arready}, 3'b111);

        // Table-driven vectors
        for (int v = 0; v < 18; v++) begin
            if (vecs[v].is_wr) begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].mode,
                         vecs[v].hold, vecs[v].exp_resp, vecs[v].exp_pulses);
                if (vecs[v].reg_idx >= 0) exp_regs[vecs[v].reg_idx] = vecs[v].exp_reg;
            end else begin
                do_read(vecs[v].addr, vecs[v].status, vecs[v].hold,
                        vecs[v].exp_resp, vecs[v].exp_rdata);
            end
            chk($sformatf("regs_after_vec%0d", v), regs_out, exp_regs);
        end

        // Reset after AW captured but before W: everything cleared, AW discarded
        awaddr = 12'h004; awvalid = 1'b1; tick(); awvalid = 1'b0;
        chk("mid_aw_captured", {awready, wready}, 2'b01);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_regs", regs_out, 256'h0);
        chk("mid_rst_outputs", {awready, wready, arready, bvalid, rvalid, cmd_pulse}, 6'b0);
        exp_regs = '0;
        tick();
        resetn = 1'b1;
        tick();
        chk("mid_rst_readys", {awready, wready, arready}, 3'b111);
        wdata = 32'h0000FFFF; wstrb = 4'hF; wvalid = 1'b1; tick(); wvalid = 1'b0;
        tick(); tick(); tick();
        chk("mid_rst_no_write", {bvalid, awready, wready}, 3'b010);
        chk("mid_rst_regs_still0", regs_out, 256'h0);
        awaddr = 12'h004; awvalid = 1'b1; tick(); awvalid = 1'b0;
        lat = 1;
        while (!bvalid && lat < 10) begin tick(); lat++; end
        chk("post_rst_b_latency", lat, 2);
        chk("post_rst_bresp", bresp, 2'b00);
        bready = 1'b1; tick(); bready = 1'b0;
        exp_regs[1] = 32'h0000FFFF;
        chk("post_rst_regs", regs_out, exp_regs);

        // AR handshake on the same edge as a write commit returns the old value
        awaddr = 12'h00C; wdata = 32'h000000A5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; tick(); awvalid = 1'b0; wvalid = 1'b0;
        araddr = 12'h00C; arvalid = 1'b1; tick(); arvalid = 1'b0;
        chk("rw_same_edge", {rvalid, bvalid, rdata, rresp}, {1'b1, 1'b1, 32'h0, 2'b00});
        bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
        chk("rw_same_edge_done", {rvalid, bvalid}, 2'b00);
        exp_regs[3] = 32'h000000A5;
        chk("rw_same_edge_regs", regs_out, exp_regs);
        do_read(12'h00C, 32'h0, 0, 2'b00, 32'h000000A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
